// File: rtl/hbram_burst_scheduler.sv
// Burst scheduler for hyper_bus: moves fixed-size bursts between the write/read
// async_fifos and a circular HyperRAM region so the RAM acts as one large FIFO.
module hbram_burst_scheduler #(
    parameter int unsigned BIT_WIDTH     = 16,
    parameter int unsigned BURST_LEN     = 512,
    parameter int unsigned CNT_WIDTH     = 9,
    parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
    parameter int unsigned REGION_BURSTS = 1024,
    parameter int unsigned ACK_TIMEOUT   = 255,
    localparam int unsigned FILL_W       = $clog2(REGION_BURSTS) + 1
) (
    input  logic                 ram_clock,
    input  logic                 ram_reset,
    input  logic                 hbc_cal_pass,
    input  logic                 ctrl_idle,
    input  logic [CNT_WIDTH-1:0] wr_fifo_count,
    input  logic [CNT_WIDTH-1:0] rd_fifo_space,
    input  logic                 wr_req_en,
    input  logic                 rd_req_en,
    output logic                 ram_en,
    output logic                 rw_ctrl,
    output logic [31:0]          ram_addr,
    output logic [10:0]          ram_burst_len,
    output logic [FILL_W-1:0]    fill_level,
    output logic                 region_full,
    output logic                 region_empty,
    output logic                 busy,
    output logic                 ack_err
);

    localparam int unsigned IDX_W = $clog2(REGION_BURSTS);
    localparam int unsigned BW    = BURST_LEN / 2;
    localparam int unsigned BB    = BURST_LEN * BIT_WIDTH / 8;
    localparam int unsigned TO_W  = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_CAL,
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] wi, ri;
    logic             last_op;      // 1 = read
    logic [TO_W-1:0]  to_cnt;
    logic             wr_elig, rd_elig, pick_rd, commit, timeout;

    assign ram_burst_len = 11'(BURST_LEN);
    assign region_full   = (fill_level == FILL_W'(REGION_BURSTS));
    assign region_empty  = (fill_level == '0);

    always_comb begin
        wr_elig = wr_req_en && (32'(wr_fifo_count) >= BW) && !region_full;
        rd_elig = rd_req_en && (32'(rd_fifo_space) >= BW) && !region_empty;
        // With both eligible, alternate against the last committed op.
        pick_rd = rd_elig && (!wr_elig || !last_op);
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_CAL: begin
                if (hbc_cal_pass) state_nxt = S_IDLE;
            end
            S_IDLE: begin
                if (!hbc_cal_pass)
                    state_nxt = S_CAL;
                else if (ctrl_idle && (wr_elig || rd_elig))
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = S_ACK;
            S_ACK: begin
                if (!ctrl_idle) begin
                    state_nxt = S_DONE;
                end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                if (ctrl_idle) begin
                    commit    = 1'b1;
                    state_nxt = hbc_cal_pass ? S_IDLE : S_CAL;
                end
            end
            default: state_nxt = S_CAL;
        endcase
    end

    always_ff @(posedge ram_clock) begin
        if (ram_reset) begin
            state      <= S_CAL;
            ram_en     <= 1'b0;
            rw_ctrl    <= 1'b0;
            ram_addr   <= BASE_ADDR;
            busy       <= 1'b0;
            ack_err    <= 1'b0;
            fill_level <= '0;
            wi         <= '0;
            ri         <= '0;
            last_op    <= 1'b1;
            to_cnt     <= '0;
        end else begin
            state  <= state_nxt;
            ram_en <= (state_nxt == S_ISSUE);

            // Command is latched once on leaving S_IDLE and held until commit.
            if (state == S_IDLE && state_nxt == S_ISSUE) begin
                rw_ctrl  <= pick_rd;
                ram_addr <= BASE_ADDR + 32'(pick_rd ? ri : wi) * BB;
            end

            if (state_nxt == S_ISSUE)
                busy <= 1'b1;
            else if (commit || timeout)
                busy <= 1'b0;

            if (state == S_ISSUE)
                to_cnt <= '0;
            else if (state == S_ACK)
                to_cnt <= to_cnt + 1'b1;

            if (timeout)
                ack_err <= 1'b1;

            if (commit) begin
                last_op <= rw_ctrl;
                if (rw_ctrl) begin
                    ri         <= ri + 1'b1;
                    fill_level <= fill_level - 1'b1;
                end else begin
                    wi         <= wi + 1'b1;
                    fill_level <= fill_level + 1'b1;
                end
            end
        end
    end

endmodule
